// File: rtl/tcb_lib_arbiter.sv
// Round-robin TCB manager arbiter with bus lock and stall hold.
// Drives the multiplexer request select and a response select delayed by DLY.
module tcb_lib_arbiter #(
  parameter int unsigned IFN = 3,
  parameter int unsigned IFL = $clog2(IFN),
  parameter int unsigned DLY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IFN-1:0] vld,
  input  logic [IFN-1:0] lck,
  input  logic           rdy,
  output logic [IFL-1:0] sel,
  output logic [IFN-1:0] gnt,
  output logic [IFL-1:0] sel_rsp,
  output logic           own
);

  logic [IFL-1:0] ptr_q, ptr_d;
  logic           own_q, own_d;
  logic [IFL-1:0] own_idx_q, own_idx_d;
  logic           hsk;
  logic           any_gnt;

  always_comb begin
    logic           found;
    int unsigned    idx;
    logic [IFL-1:0] cand;
    sel   = own_idx_q;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    if (rst) begin
      sel = '0;
    end else if (own_q) begin
      sel            = own_idx_q;
      gnt[own_idx_q] = vld[own_idx_q];
    end else begin
      // Scan from the priority pointer, wrapping at IFN rather than 2**IFL.
      for (int unsigned k = 0; k < IFN; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= IFN) idx = idx - IFN;
        cand = IFL'(idx);
        if (!found && vld[cand]) begin
          found     = 1'b1;
          sel       = cand;
          gnt       = '0;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  assign any_gnt = |gnt;
  assign hsk     = any_gnt & rdy;
  assign own     = own_q & ~rst;

  always_comb begin
    ptr_d     = ptr_q;
    own_d     = own_q;
    own_idx_d = own_idx_q;
    if (any_gnt && !rdy) begin
      own_d     = 1'b1;
      own_idx_d = sel;
    end else if (hsk && lck[sel]) begin
      own_d     = 1'b1;
      own_idx_d = sel;
    end else if (hsk) begin
      own_d     = 1'b0;
      own_idx_d = sel;
      ptr_d     = (32'(sel) == IFN - 1) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      own_q     <= 1'b0;
      own_idx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      own_idx_q <= own_idx_d;
    end
  end

  if (DLY > 0) begin : g_dly
    logic [IFL-1:0] stg_q [DLY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < DLY; k++) stg_q[k] <= '0;
      end else begin
        // Stage 0 holds between handshakes; later stages always shift.
        stg_q[0] <= hsk ? sel : stg_q[0];
        for (int unsigned k = 1; k < DLY; k++) stg_q[k] <= stg_q[k-1];
      end
    end

    assign sel_rsp = rst ? '0 : stg_q[DLY-1];
  end else begin : g_nodly
    assign sel_rsp = sel;
  end

endmodule

// File: doc/tcb_lib_arbiter.md
# tcb_lib_arbiter

Round-robin arbiter with bus-lock support that shares one TCB subordinate port among IFN managers. It drives the request-path select of a TCB multiplexer and produces a delayed response-path select matched to the handshake response delay DLY. It sits between the manager-side TCB interfaces and the multiplexer, which is the mirror of the decoder/demultiplexer pair on the subordinate side.

## Interface
- `IFN`, 3: number of manager interfaces; valid range ≥2.
- `IFL`, `$clog2(IFN)`: select width.
- `DLY`, `TCB_HSK_DEF.DLY`: response delay in cycles, from request handshake to response; valid range ≥0.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `vld` input IFN: request valid per manager (`tcb[i].vld`).
- `lck` input IFN: request lock per manager (`tcb[i].req.lck`).
- `rdy` input 1: ready of the shared subordinate port.
- `sel` output IFL: request-path select to the multiplexer.
- `gnt` output IFN: one-hot grant; `gnt[i]` means manager i is connected and its `vld` is high.
- `sel_rsp` output IFL: response-path select, `sel` of the handshake DLY cycles earlier.
- `own` output 1: ownership (hold or lock) is active.

## Operation
- State: `ptr` (IFL, round-robin priority pointer), `own` (1), `own_idx` (IFL), response select shift register of DLY entries, each IFL wide.
- Reset values: `ptr`=0, `own`=0, `own_idx`=0, all shift-register entries 0. While `rst`=1: `gnt`=0, `sel`=0, `sel_rsp`=0.
- Arbitration, combinational, zero latency:
  - If `own`=1: `sel`=`own_idx`; `gnt[own_idx]`=`vld[own_idx]`; all other grants 0, even when the owner is idle.
  - If `own`=0: `sel`=first index i scanning `ptr`, `ptr+1`, … modulo IFN with `vld[i]`=1; `gnt` is one-hot at `sel`.
  - If `own`=0 and no `vld`: `sel` holds the last registered `own_idx`; `gnt`=0.
- Handshake: `hsk = |gnt & rdy`.
- State update each cycle, in priority order:
  - Granted, `vld`=1, `rdy`=0 (stall): `own`<=1, `own_idx`<=`sel`. This keeps the request stable, as TCB requires.
  - `hsk` with `lck[sel]`=1: `own`<=1, `own_idx`<=`sel`. `ptr` is unchanged.
  - `hsk` with `lck[sel]`=0: `own`<=0, `own_idx`<=`sel`, `ptr`<=(`sel`+1) mod IFN, with the wrap computed explicitly, not by IFL truncation, so non-power-of-two IFN is handled.
  - No grant and `own`=0: no change.
- Response select:
  - On `hsk`, `sel` is pushed into stage 0; the stages shift every cycle.
  - `sel_rsp` = stage DLY-1. If DLY=0, `sel_rsp`=`sel` combinationally.
  - Non-handshake cycles push the previous stage-0 value, i.e. hold. `sel_rsp` is only meaningful in the cycle the response is due.
- A lock is released only by the owner's own handshake with `lck`=0. There is no timeout.

## Timing
- Request-path latency is 0 cycles: `vld` to `gnt`/`sel` is purely combinational, with no path from `rdy` to `sel`.
- Grant changes take effect the cycle after the handshake.
- Back-to-back handshakes from different managers are allowed every cycle.
- `sel_rsp` is valid exactly DLY cycles after the corresponding `hsk`.
- Reset asserted mid-lock or mid-stall: the next cycle shows `own`=0 and `ptr`=0, and all shift entries are cleared. Responses still in flight are discarded; the bench must not check them.
- A simultaneous new `vld` from a higher-priority manager while `own`=1 has no effect until ownership is released.

## Test plan
- Fairness: IFN=3, DLY=1, `vld`=3'b111 held, `rdy`=1, `lck`=0 from reset -> `sel` sequence 0,1,2,0,1,2; `sel_rsp` is the same sequence lagged by 1 cycle.
- Sparse request with wrap: `ptr`=2, `vld`=3'b011 -> `sel`=0; after the handshake `ptr`=1. Then `vld`=3'b110 -> `sel`=1.
- Stall hold: manager 1 granted, `rdy`=0 for 3 cycles while `vld[0]` and `vld[2]` rise -> `sel`=1 and `gnt`=3'b010 throughout. On `rdy`=1 the handshake completes, and the next grant goes to 2.
- Lock: manager 0 handshakes with `lck`=1, goes idle 2 cycles, then handshakes with `lck`=0, while `vld[1]`=1 throughout -> `gnt[1]`=0 during the lock and `own`=1. Manager 1 is granted the cycle after the unlock handshake.
- DLY=0 and DLY=2 builds -> `sel_rsp`=`sel` in the same cycle, and `sel_rsp`=`sel` from 2 cycles after the handshake, respectively.
- Reset mid-lock: `rst`=1 for 1 cycle while manager 2 owns the bus -> `own`=0, `ptr`=0, `gnt`=0 during reset. With `vld`=3'b101 afterwards, `sel`=0.
